uart_rx_param: RTL
==================

Name: uart_rx_param

Overview:
- Parametrised UART receiver, successor to the fixed 8-bit receiver.
- Handles standard idle-high async frames: start bit, DATA_BITS data bits LSB first, optional parity, 1 or 2 stop bits.
- Recovers bits by oversampling at an externally supplied tick and samples each bit at mid-bit.
- Delivers each received word, with per-word error flags, through a one-deep valid/ready holding register to the downstream consumer.

Parameters:
- DATA_BITS, 8, data bits per frame; legal range 5..9.
- OVERSAMPLE, 16, baud_tick pulses per bit period; even, minimum 4.
- SYNC_STAGES, 2, flops in the rxd metastability synchroniser; minimum 2.

Ports:
- clk  input  1  clock.
- rst  input  1  asynchronous reset, active-high.
- baud_tick  input  1  oversample enable; one-clk pulse, OVERSAMPLE per bit period.
- rxd  input  1  serial line; idle high; asynchronous to clk.
- parity_mode  input  2  00 none, 01 even, 10 odd, 11 treated as none; sampled at start-bit acceptance.
- two_stop  input  1  0 = 1 stop bit, 1 = 2 stop bits; sampled at start-bit acceptance.
- rx_data  output  DATA_BITS  received word, held while rx_valid.
- rx_valid  output  1  word available.
- rx_ready  input  1  consumer accepts word when rx_valid && rx_ready.
- parity_error  output  1  per-word flag, valid with rx_valid.
- frame_error  output  1  per-word flag, valid with rx_valid; a stop bit sampled low.
- overrun  output  1  one-clk pulse when a completed frame is dropped.
- busy  output  1  high from start-bit acceptance to end of last stop-bit sample.

Behaviour:
- Reset:
  - all outputs 0.
  - Synchroniser flops 1.
  - FSM IDLE, counters 0.
  - Asserting rst mid-frame aborts the frame; no word is delivered.
- rxd passes through SYNC_STAGES flops; all logic uses the synchronised value rs.
- Tick counter advances only on baud_tick; all bit timing is in ticks.
- IDLE:
  - on a baud_tick with rs=0, go to START and clear the tick counter.
- START:
  - after OVERSAMPLE/2 ticks, sample rs.
  - rs=0: accept the start bit, latch parity_mode and two_stop, set busy, go to DATA.
  - rs=1: glitch; return to IDLE with no flags.
- DATA:
  - sample every OVERSAMPLE ticks after the start mid-point.
  - Shift bits in LSB first; exactly DATA_BITS samples.
  - Then go to PARITY if the latched mode is 01 or 10, else to STOP.
- PARITY:
  - one sample.
  - Even: error if (XOR of data) != parity bit.
  - Odd: error if (XOR of data) == parity bit.
- STOP:
  - one or two samples, per the latched two_stop.
  - Any stop sample = 0 sets frame_error for the word.
  - The FSM does not resynchronise on a bad stop bit; it returns to IDLE after the last stop sample.
  - A low line is then seen as a new start.
- Delivery, on the clk after the last stop-bit sample:
  - If rx_valid=0, or rx_valid=1 && rx_ready=1 in that same cycle: load rx_data and flags, then set rx_valid=1.
  - Otherwise: keep the old word, pulse overrun for 1 clk, discard the new word.
- Handshake:
  - rx_valid stays high, and rx_data and flags stay stable, until a cycle with rx_ready=1.
  - rx_valid then drops on the next clk unless a new word loads in that same cycle (back-to-back allowed).
  - rx_ready while rx_valid=0 has no effect.
- busy falls in the same clk as delivery.
- Reception continues while a word is held; buffering is exactly one word.
- parity_mode and two_stop changes mid-frame are ignored until the next start-bit acceptance.
- Latency:
  - Measure from the rxd edge to the rs edge: SYNC_STAGES clks.
  - Measure from the last stop mid-sample to rx_valid: 1 clk.

Test Plan:
- OVERSAMPLE=16, baud_tick tied 1, parity none, two_stop=0, rx_ready=1; send 0xA5 (stop 1):
  - rx_valid pulses 1 clk with rx_data=0xA5, parity_error=0, frame_error=0.
  - rx_valid asserts 1 clk after the stop-bit mid-sample.
- parity_mode=01, send 0xA5 with parity bit 0:
  - no error.
  - Resend with parity bit 1: parity_error=1, rx_data=0xA5.
  - parity_mode=10 with parity bit 1: no error.
- two_stop=1, send 0x3C with the second stop bit driven 0: frame_error=1, rx_data=0x3C.
  - Repeat with both stop bits 1: frame_error=0.
- rx_ready=0; send 0x11 then 0x22 back-to-back:
  - rx_data holds 0x11, rx_valid stays 1, and overrun pulses once at the end of 0x22.
  - Raising rx_ready yields 0x11 only.
- Low glitch of 4 clks on an idle line: no busy at the START sample, no rx_valid, FSM back in IDLE.
- Assert rst for 1 clk mid-DATA of frame 0x5A:
  - all outputs 0, no word delivered.
  - A following clean 0x5A frame is received correctly.
  - DATA_BITS=5 build: send 0x15 and receive rx_data=5'h15.

Source files
------------

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver: start/data/optional parity/1-2 stop bits,
// mid-bit sampling on baud_tick, one-deep valid/ready output register with per-word flags.

// state  | meaning
// IDLE   | line idle, waiting for a low sample on a baud_tick
// START  | half a bit period in, confirming the start bit
// DATA   | sampling DATA_BITS data bits, LSB first
// PARITY | sampling the parity bit (even/odd modes only)
// STOP   | sampling one or two stop bits, then delivering the word
module uart_rx_param #(
    parameter int DATA_BITS   = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rxd,
    input  logic [1:0]           parity_mode,
    input  logic                 two_stop,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_error,
    output logic                 frame_error,
    output logic                 overrun,
    output logic                 busy
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [TW-1:0] HALF_LOAD = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] FULL_LOAD = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BITS_LOAD = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [SYNC_STAGES-1:0] sync;
    logic                   rs;
    logic [TW-1:0]          tick_cnt;
    logic [BW-1:0]          bit_cnt;
    logic [DATA_BITS-1:0]   shift_reg;
    logic                   par_en_q;
    logic                   par_odd_q;
    logic                   stop_left;
    logic                   par_err_q;
    logic                   frame_err_q;

    logic                   smp;
    logic                   start_det;
    logic                   start_ok;
    logic                   data_smp;
    logic                   par_smp;
    logic                   stop_smp;
    logic                   frame_done;

    // rxd is asynchronous; only the last synchroniser stage is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rxd};
        end
    end

    assign rs  = sync[SYNC_STAGES-1];
    assign smp = baud_tick && (tick_cnt == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        start_det  = 1'b0;
        start_ok   = 1'b0;
        data_smp   = 1'b0;
        par_smp    = 1'b0;
        stop_smp   = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE: begin
                if (baud_tick && !rs) begin
                    start_det = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (smp) begin
                    if (!rs) begin
                        start_ok  = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (smp) begin
                    data_smp = 1'b1;
                    if (bit_cnt == '0) begin
                        state_nxt = par_en_q ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (smp) begin
                    par_smp   = 1'b1;
                    state_nxt = STOP;
                end
            end
            STOP: begin
                if (smp) begin
                    stop_smp = 1'b1;
                    if (!stop_left) begin
                        frame_done = 1'b1;
                        state_nxt  = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Down-counting tick timer: first terminal count lands mid start bit,
    // later ones every full bit period after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
        end else if (start_det) begin
            tick_cnt <= HALF_LOAD;
        end else if (baud_tick && (state != IDLE)) begin
            tick_cnt <= (tick_cnt == '0) ? FULL_LOAD : tick_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt   <= '0;
            shift_reg <= '0;
        end else if (start_ok) begin
            bit_cnt <= BITS_LOAD;
        end else if (data_smp) begin
            shift_reg <= {rs, shift_reg[DATA_BITS-1:1]};
            if (bit_cnt != '0) begin
                bit_cnt <= bit_cnt - 1'b1;
            end
        end
    end

    // Frame configuration is captured once per frame at start-bit acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_en_q    <= 1'b0;
            par_odd_q   <= 1'b0;
            stop_left   <= 1'b0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (start_ok) begin
            par_en_q    <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
            par_odd_q   <= (parity_mode == 2'b10);
            stop_left   <= two_stop;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            if (par_smp) begin
                par_err_q <= par_odd_q ? ((^shift_reg) == rs) : ((^shift_reg) != rs);
            end
            if (stop_smp) begin
                stop_left <= 1'b0;
                if (!rs) begin
                    frame_err_q <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else if (start_ok) begin
            busy <= 1'b1;
        end else if (frame_done) begin
            busy <= 1'b0;
        end
    end

    // The final stop sample is folded straight into the delivered frame_error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            overrun      <= 1'b0;
        end else begin
            overrun <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data      <= shift_reg;
                    parity_error <= par_err_q;
                    frame_error  <= frame_err_q | ~rs;
                    rx_valid     <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
